div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
Multi-cycle sequencer for integer division in the EX stage. It replaces the single-cycle combinational divider with a radix-2 restoring loop of one quotient bit per clock. It handles the signed/unsigned pre-conditioning, divide-by-zero short-circuit, sign correction and pipeline stall/flush handshake. EX drives operands and start; the block stalls the pipeline until the result is valid.

Parameters:
CNT_W, 5, width of the iteration counter; 2**CNT_W equals the data width (32).
DIVZ_Q, 32'hFFFF_FFFF, quotient returned for a zero divisor.

Ports:
clk  input  1  core clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
div_start  input  1  EX requests a divide this cycle; level, sampled only in IDLE.
funct  input  `FUNCT_BUS  operation; `FUNCT_DIV = signed, any other = unsigned.
operand_1  input  `DATA_BUS  dividend.
operand_2  input  `DATA_BUS  divisor.
flush  input  1  pipeline flush; aborts any divide in progress.
stall_req  output  1  asks the pipeline control to hold IF/ID/EX.
busy  output  1  high in any state other than IDLE.
result_valid  output  1  one-cycle pulse; quotient/remainder valid.
quotient  output  `DATA_BUS  registered quotient.
remainder  output  `DATA_BUS  registered remainder.

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, all working registers 0, quotient=0, remainder=0, result_valid=0, busy=0.
- States: IDLE, BUSY, FIX, DONE.
- Transitions from IDLE on div_start=1 and flush=0:
  - operand_2==0: go to DONE. Latch quotient=DIVZ_Q and remainder=operand_1 (raw, no sign change).
  - otherwise: go to BUSY. Latch sign flags s1=signed&op1[31] and s2=signed&op2[31]. Latch the magnitudes |op1| and |op2|, using two's complement when the flag is set. Clear the partial remainder, set cnt=0.
- BUSY, one step per edge:
  - rem_shift = {partial_rem, dividend_msb}.
  - diff = rem_shift - divisor, computed at 33 bits.
  - diff non-negative: quotient bit = 1, partial_rem = diff.
  - diff negative: quotient bit = 0, partial_rem = rem_shift.
  - The dividend register shifts left and the quotient bit enters at the LSB.
  - cnt increments; the step with cnt==31 moves to FIX.
- FIX, one edge, then go to DONE:
  - quotient = (s1^s2) ? -q : q.
  - remainder = s1 ? -r : r, so the remainder takes the sign of the dividend.
- DONE: result_valid=1 for exactly this cycle, then IDLE on the next edge. quotient/remainder hold until the next accepted start.
- Latency, with E0 = the edge that accepts the start:
  - normal divide: result_valid high in the cycle after E33, i.e. 34 cycles.
  - divide-by-zero: result_valid high in the cycle after E0, i.e. 1 cycle.
- stall_req = (IDLE & div_start & ~flush) | BUSY | FIX. It is combinational so EX freezes in the start cycle. It is low in DONE, so the instruction advances with the result.
- Overflow: signed 0x80000000 / 0xFFFFFFFF needs no special case. It gives quotient 0x80000000, remainder 0.
- flush:
  - in BUSY or FIX: return to IDLE on the next edge, with no result_valid and outputs unchanged.
  - in IDLE together with div_start: flush wins and nothing starts.
  - in DONE: no effect, since DONE already returns to IDLE.
- div_start outside IDLE is ignored. Operand inputs are don't-care after E0 because they are latched.

Decomposition:
- Shared defines header, alongside `DATA_BUS/`FUNCT_BUS/`FUNCT_DIV: state encodings DIV_IDLE/DIV_BUSY/DIV_FIX/DIV_DONE (2 bits).
- One sub-module, div_step: combinational single restoring step.
  - inputs: partial_rem, dividend_msb, divisor.
  - outputs: next_rem, q_bit.
  - The FSM, counter, sign handling and registers stay in div_seq_ctrl.

Test Plan:
- Unsigned: funct≠DIV, 7 / 2 → after 34 cycles quotient=3, remainder=1, result_valid for 1 cycle; stall_req high from the start cycle through FIX.
- Signed: FUNCT_DIV, 0xFFFFFFF9 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also 7 / 0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
- Overflow: FUNCT_DIV, 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, latency 34.
- Divide-by-zero: 0x1234 / 0 (signed and unsigned) → result_valid the cycle after the start edge, quotient=0xFFFFFFFF, remainder=0x1234.
- Flush and reset:
  - flush in the 10th BUSY cycle → IDLE next edge, no result_valid, prior outputs unchanged; a start the following cycle (100 / 7) returns 14 / 2.
  - rst asserted mid-BUSY asynchronously clears all outputs and state to 0/IDLE.
- Start/flush collision: div_start and flush both high in IDLE → stall_req=0, state stays IDLE. A div_start pulse while BUSY is ignored and the first result is unaffected.

Source files
------------

// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the sequential divider slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: data/funct widths, FUNCT_DIV encoding, divider state encodings,
//           and a conditional two's-complement helper.
package div_seq_ctrl_pkg;

   localparam int DATA_W  = 32;
   localparam int FUNCT_W = 3;

   typedef logic [DATA_W-1:0]  data_t;
   typedef logic [FUNCT_W-1:0] funct_t;

   // Signed divide; every other funct value selects unsigned.
   localparam funct_t FUNCT_DIV = 3'b100;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // Negate v when neg is set; used both for magnitudes and sign fix-up.
   function automatic data_t neg_if(input data_t v, input logic neg);
      return neg ? data_t'(-v) : v;
   endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// EX-stage <-> divider handshake bundle.
// Latency: n/a (wires only).
// Backpressure: stall_req from the divider holds IF/ID/EX until result_valid.
// Ports: master = EX side (drives start/operands/flush), slave = divider.
interface div_seq_ctrl_if;
   import div_seq_ctrl_pkg::*;

   logic   div_start;
   funct_t funct;
   data_t  operand_1;
   data_t  operand_2;
   logic   flush;
   logic   stall_req;
   logic   busy;
   logic   result_valid;
   data_t  quotient;
   data_t  remainder;

   modport master (
      output div_start, funct, operand_1, operand_2, flush,
      input  stall_req, busy, result_valid, quotient, remainder
   );

   modport slave (
      input  div_start, funct, operand_1, operand_2, flush,
      output stall_req, busy, result_valid, quotient, remainder
   );
endinterface

// File: rtl/div_seq_ctrl_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract.
// Latency: combinational.
// Backpressure: none.
// Ports: partial_rem/dividend_msb/divisor in; next_rem/q_bit out.
module div_step
   import div_seq_ctrl_pkg::*;
(
   input  data_t partial_rem,
   input  logic  dividend_msb,
   input  data_t divisor,
   output data_t next_rem,
   output logic  q_bit
);

   logic [DATA_W:0] rem_shift;
   logic [DATA_W:0] diff;

   assign rem_shift = {partial_rem, dividend_msb};
   assign diff      = rem_shift - {1'b0, divisor};

   // partial_rem < divisor always holds, so a non-negative diff is below
   // 2**32 and bit 32 is a clean sign bit for the 33-bit subtraction.
   assign q_bit    = ~diff[DATA_W];
   assign next_rem = q_bit ? diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed/unsigned divider sequencer for EX, one quotient bit/clk.
// Latency: 34 cycles start-to-result_valid; 1 cycle for a zero divisor.
// Backpressure: stall_req holds the pipeline from the start cycle through FIX;
//               flush aborts BUSY/FIX with no result and outputs unchanged.
// Ports: clk, rst (async, active-high), bus (div_seq_ctrl_if.slave).
module div_seq_ctrl
   import div_seq_ctrl_pkg::*;
#(
   parameter int          CNT_W  = 5,
   parameter logic [31:0] DIVZ_Q = 32'hFFFF_FFFF
) (
   input logic           clk,
   input logic           rst,
   div_seq_ctrl_if.slave bus
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   data_t            dvd_q;    // dividend magnitude, becomes the raw quotient
   data_t            dvs_q;    // divisor magnitude
   data_t            prem_q;   // partial remainder
   logic             s1_q, s2_q;
   data_t            quot_q, rem_q;

   logic  accept, divz, is_signed, s1, s2;
   logic  stall_req_c, busy_c, result_valid_c;
   data_t step_rem;
   logic  step_q_bit;

   assign is_signed = (bus.funct == FUNCT_DIV);
   assign s1        = is_signed & bus.operand_1[DATA_W-1];
   assign s2        = is_signed & bus.operand_2[DATA_W-1];
   assign divz      = (bus.operand_2 == '0);
   // Flush beats a simultaneous start.
   assign accept    = (state_q == DIV_IDLE) & bus.div_start & ~bus.flush;

   div_step u_step (
      .partial_rem  (prem_q),
      .dividend_msb (dvd_q[DATA_W-1]),
      .divisor      (dvs_q),
      .next_rem     (step_rem),
      .q_bit        (step_q_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= DIV_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      stall_req_c    = 1'b0;
      busy_c         = 1'b1;
      result_valid_c = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            busy_c      = 1'b0;
            // Combinational so EX freezes in the very cycle it issues start.
            stall_req_c = accept;
            if (accept) state_d = divz ? DIV_DONE : DIV_BUSY;
         end
         DIV_BUSY: begin
            stall_req_c = 1'b1;
            if (bus.flush)        state_d = DIV_IDLE;
            else if (&cnt_q)      state_d = DIV_FIX;
         end
         DIV_FIX: begin
            stall_req_c = 1'b1;
            state_d     = bus.flush ? DIV_IDLE : DIV_DONE;
         end
         DIV_DONE: begin
            // Stall drops here so the instruction leaves EX with the result.
            result_valid_c = 1'b1;
            state_d        = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         dvd_q  <= '0;
         dvs_q  <= '0;
         prem_q <= '0;
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         quot_q <= '0;
         rem_q  <= '0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (accept) begin
                  if (divz) begin
                     quot_q <= DIVZ_Q;
                     rem_q  <= bus.operand_1;
                  end else begin
                     s1_q   <= s1;
                     s2_q   <= s2;
                     dvd_q  <= neg_if(bus.operand_1, s1);
                     dvs_q  <= neg_if(bus.operand_2, s2);
                     prem_q <= '0;
                     cnt_q  <= '0;
                  end
               end
            end
            DIV_BUSY: begin
               if (!bus.flush) begin
                  prem_q <= step_rem;
                  dvd_q  <= {dvd_q[DATA_W-2:0], step_q_bit};
                  cnt_q  <= cnt_q + 1'b1;
               end
            end
            DIV_FIX: begin
               // Remainder follows the dividend's sign (truncating division).
               if (!bus.flush) begin
                  quot_q <= neg_if(dvd_q, s1_q ^ s2_q);
                  rem_q  <= neg_if(prem_q, s1_q);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.stall_req    = stall_req_c;
   assign bus.busy         = busy_c;
   assign bus.result_valid = result_valid_c;
   assign bus.quotient     = quot_q;
   assign bus.remainder    = rem_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;
   import div_seq_ctrl_pkg::*;

   localparam logic [2:0] F_S = 3'b100;
   localparam logic [2:0] F_U = 3'b101;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   div_seq_ctrl_if bus();

   div_seq_ctrl #(.CNT_W(5), .DIVZ_Q(32'hFFFF_FFFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference division from the arithmetic definition (64-bit, no overflow).
   function automatic void ref_div(input logic [2:0] f, input logic [31:0] a, b,
                                   output logic [31:0] q, output logic [31:0] r);
      longint sa, sb, lq, lr;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         if (f == FUNCT_DIV) begin
            sa = $signed(a);
            sb = $signed(b);
         end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
         end
         lq = sa / sb;
         lr = sa % sb;
         q  = lq[31:0];
         r  = lr[31:0];
      end
   endfunction

   // Transaction-level model: cycles left in the busy window, done pulse, held results.
   int          m_left = 0;
   bit          m_done = 1'b0;
   logic [31:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_left > 0) begin
         if (bus.flush) m_left = 0;
         else begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1; m_q = m_pq; m_r = m_pr;
            end
         end
      end else if (bus.div_start && !bus.flush) begin
         ref_div(bus.funct, bus.operand_1, bus.operand_2, m_pq, m_pr);
         if (bus.operand_2 == 32'd0) begin
            m_done = 1'b1; m_q = m_pq; m_r = m_pr;
         end else begin
            m_left = 33;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic idle;
         idle = (m_left == 0) && !m_done;
         check("cmp stall_req", bus.stall_req, (idle && bus.div_start && !bus.flush) || (m_left > 0));
         check("cmp busy", bus.busy, (m_left > 0) || m_done);
         check("cmp result_valid", bus.result_valid, m_done);
         check("cmp quotient", bus.quotient, m_q);
         check("cmp remainder", bus.remainder, m_r);
      end
   end

   // Called at posedge+2; returns at posedge+2 after the idle cycle following DONE.
   task automatic run_div(input string nm, input logic [2:0] f, input logic [31:0] a, b,
                          input logic [31:0] eq, er, input int elat, input int poke);
      int n;
      bit found;
      bus.funct = f; bus.operand_1 = a; bus.operand_2 = b; bus.div_start = 1'b1;
      #1 check({nm, " stall_start"}, bus.stall_req, 32'd1);
      @(posedge clk); #2;
      bus.div_start = 1'b0;
      bus.operand_1 = $urandom;
      bus.operand_2 = $urandom;
      n = 1; found = 1'b0;
      while (!found && n <= 60) begin
         @(negedge clk);
         if (bus.result_valid) found = 1'b1;
         else begin
            @(posedge clk); #2;
            n++;
            bus.div_start = (n == poke);
         end
      end
      bus.div_start = 1'b0;
      check({nm, " latency"}, 32'(n), 32'(elat));
      check({nm, " quotient"}, bus.quotient, eq);
      check({nm, " remainder"}, bus.remainder, er);
      @(posedge clk); #2;
      check({nm, " valid_pulse"}, bus.result_valid, 32'd0);
   endtask

   initial begin
      bus.div_start = 1'b0; bus.flush = 1'b0; bus.funct = F_U;
      bus.operand_1 = '0; bus.operand_2 = '0;
      repeat (2) @(posedge clk);
      #2;
      check("reset quotient", bus.quotient, 32'd0);
      check("reset remainder", bus.remainder, 32'd0);
      check("reset busy", bus.busy, 32'd0);
      check("reset result_valid", bus.result_valid, 32'd0);
      check("reset stall_req", bus.stall_req, 32'd0);
      chk_en = 1'b1;
      rst = 1'b0;
      @(posedge clk); #2;

      run_div("u7div2",    F_U, 32'd7,          32'd2,          32'd3,          32'd1,          34, 0);
      run_div("s-7div2",   F_S, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  34, 0);
      run_div("s7div-2",   F_S, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          34, 0);
      run_div("s_ovf",     F_S, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          34, 0);
      run_div("s_divz",    F_S, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1,  0);
      run_div("u_divz",    F_U, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1,  0);
      run_div("u_big",     F_U, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          34, 0);

      // start and flush together in IDLE: nothing starts
      bus.funct = F_U; bus.operand_1 = 32'd50; bus.operand_2 = 32'd5;
      bus.div_start = 1'b1; bus.flush = 1'b1;
      #1 check("collide stall_req", bus.stall_req, 32'd0);
      @(posedge clk); #2;
      check("collide busy", bus.busy, 32'd0);
      bus.div_start = 1'b0; bus.flush = 1'b0;
      @(posedge clk); #2;

      // flush in the 10th BUSY cycle
      bus.funct = F_U; bus.operand_1 = 32'd1000; bus.operand_2 = 32'd3; bus.div_start = 1'b1;
      @(posedge clk); #2;
      bus.div_start = 1'b0;
      repeat (9) begin @(posedge clk); #2; end
      check("flush busy_before", bus.busy, 32'd1);
      bus.flush = 1'b1;
      @(posedge clk); #2;
      bus.flush = 1'b0;
      check("flush busy", bus.busy, 32'd0);
      check("flush quotient_held", bus.quotient, 32'h7FFF_FFFC);
      check("flush remainder_held", bus.remainder, 32'd1);
      run_div("u100div7",  F_U, 32'd100,        32'd7,          32'd14,         32'd2,          34, 0);

      // stray start while busy is ignored
      run_div("s_poke",    F_S, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  34, 5);

      // async reset mid-BUSY
      bus.funct = F_U; bus.operand_1 = 32'h10000; bus.operand_2 = 32'h10; bus.div_start = 1'b1;
      @(posedge clk); #2;
      bus.div_start = 1'b0;
      repeat (5) begin @(posedge clk); #2; end
      #1 rst = 1'b1;
      #1;
      check("arst quotient", bus.quotient, 32'd0);
      check("arst remainder", bus.remainder, 32'd0);
      check("arst busy", bus.busy, 32'd0);
      check("arst stall_req", bus.stall_req, 32'd0);
      check("arst result_valid", bus.result_valid, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #2;
      run_div("u_after_rst", F_U, 32'd45,       32'd6,          32'd7,          32'd3,          34, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
